hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline scheduler for the 5-stage MIPS core. Sits beside the decode control unit.
- Generates stage write-enables, flushes and bubbles for load-use hazards, JR/JALR register hazards, jumps and taken branches.
- Generates EX operand forwarding selects.
- Sequences the multi-cycle MUL unit in EX: freezes the front of the pipe until the product is ready.

Parameters:
- MUL_CYCLES, 4: cycles a MUL occupies EX; legal range 1..16.
- CNT_W, 4: width of the MUL wait counter; must satisfy 2^CNT_W >= MUL_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs, id_rt  in  5 each  source register addresses of the instruction in ID.
- id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt.
- id_is_jump  in  1  J or JAL in ID (PCSrc=Jump).
- id_is_jr  in  1  JR or JALR in ID (PCSrc=JumpR); target read from rs in ID.
- ex_rs, ex_rt  in  5 each  source register addresses in EX.
- ex_wr_addr  in  5  destination register of the EX instruction.
- ex_reg_write, ex_mem_read  in  1 each  EX instruction writes a register / is a load.
- ex_is_mul  in  1  MUL in EX.
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_wr_addr  in  5  destination register in MEM.
- mem_reg_write, mem_mem_read  in  1 each  MEM instruction writes a register / is a load.
- wb_wr_addr  in  5  destination register in WB.
- wb_reg_write  in  1  WB instruction writes a register.
- pc_write_en  out  1  PC may update.
- if_id_write_en, id_ex_write_en  out  1 each  pipeline register load enables.
- if_id_flush, id_ex_flush  out  1 each  replace the register contents with a NOP next edge.
- ex_mem_bubble  out  1  load a NOP into EX/MEM.
- forward_a, forward_b  out  2 each  EX operand select: 00 register file, 10 MEM ALU result, 01 WB data.
- forward_jr  out  1  ID rs value taken from the MEM ALU result.
- mul_start  out  1  one-cycle start pulse to the MUL unit.
- mul_busy  out  1  controller is in MUL_WAIT.

Behaviour:
- Reset:
  - While rst_n=0: state=RUN, cnt=0.
  - All write enables 0, both flushes 1, ex_mem_bubble 1, mul_start 0, mul_busy 0, forward_* 0.
  - Deassertion is taken synchronously at the next clk edge; normal operation starts there.
- Register $0 never matches: any address compare against 0 is false.
- Forwarding (combinational, valid in any state):
  - forward_a=10 if mem_reg_write & !mem_mem_read & mem_wr_addr==ex_rs.
  - Else forward_a=01 if wb_reg_write & wb_wr_addr==ex_rs.
  - Else forward_a=00. MEM has priority over WB.
  - forward_b: same rule using ex_rt.
  - forward_jr=1 if id_is_jr & mem_reg_write & !mem_mem_read & mem_wr_addr==id_rs.
- Hazard terms:
  - load_use = ex_mem_read & ex_reg_write & ((id_use_rs & id_rs==ex_wr_addr) | (id_use_rt & id_rt==ex_wr_addr)).
  - jr_haz = id_is_jr & ((ex_reg_write & ex_wr_addr==id_rs) | (mem_mem_read & mem_wr_addr==id_rs)).
- FSM states:
  - RUN.
  - MUL_WAIT, with down-counter cnt (CNT_W bits).
- RUN transitions:
  - ex_is_mul=1: mul_start=1.
  - If additionally MUL_CYCLES>1: mul_stall=1 this cycle; next state MUL_WAIT with cnt=MUL_CYCLES-2.
  - If MUL_CYCLES==1: no stall; stay RUN.
- MUL_WAIT transitions:
  - mul_busy=1; mul_start=0.
  - cnt!=0: mul_stall=1, cnt decrements.
  - cnt==0: mul_stall=0; next state RUN.
  - An ex_is_mul still high in MUL_WAIT never re-triggers.
  - Net effect: a MUL occupies EX exactly MUL_CYCLES cycles and produces MUL_CYCLES-1 stall cycles.
- Output priority, highest first:
  1. mul_stall: pc_write_en, if_id_write_en and id_ex_write_en all 0; ex_mem_bubble=1; no flushes.
  2. ex_branch_taken: pc_write_en=1, if_id_flush=1, id_ex_flush=1. Overrides load_use, jr_haz and id_is_jump.
  3. load_use | jr_haz: pc_write_en=0, if_id_write_en=0, id_ex_flush=1; single-cycle stall, re-evaluated each cycle. A jump in ID does not flush IF/ID while stalled.
  4. id_is_jump | id_is_jr with no hazard: if_id_flush=1.
  5. Default: all enables 1, flushes 0, ex_mem_bubble 0.
- ex_branch_taken and ex_is_mul are never both high; if they are, mul_stall wins.
- Reset asserted mid-MUL aborts the wait: state=RUN, cnt=0 immediately.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with random inputs -> enables 0, flushes 1, mul_busy 0. Release -> first edge all enables 1.
- Load-use: EX lw $8 (ex_mem_read=1, ex_wr_addr=8); ID add with id_rs=8, id_use_rs=1 -> exactly one cycle of pc_write_en=0, if_id_write_en=0, id_ex_flush=1. Repeat with id_rs=0 and ex_wr_addr=0 -> no stall.
- MUL with MUL_CYCLES=4: ex_is_mul held -> mul_start high cycle 1 only; stall for cycles 1-3 with ex_mem_bubble=1; mul_busy high cycles 2-4; cycle 4 enables 1.
- Branch: ex_branch_taken=1 together with load_use=1 -> if_id_flush=1, id_ex_flush=1, pc_write_en=1.
- Forwarding: mem_wr_addr=5 (ALU op), wb_wr_addr=5, ex_rs=5 -> forward_a=10. Set mem_mem_read=1 -> forward_a=01. JR with id_rs=5 and MEM ALU write to 5 -> forward_jr=1, no stall.
- Reset mid-MUL: drop rst_n in the 2nd MUL_WAIT cycle, then release with ex_is_mul=0 -> state RUN, mul_busy 0, no residual stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline scheduler for the 5-stage MIPS core: stalls, flushes,
// EX/JR forwarding selects and multi-cycle MUL sequencing.
module hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_is_jump,
  input  logic       id_is_jr,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] ex_wr_addr,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic       ex_is_mul,
  input  logic       ex_branch_taken,
  input  logic [4:0] mem_wr_addr,
  input  logic       mem_reg_write,
  input  logic       mem_mem_read,
  input  logic [4:0] wb_wr_addr,
  input  logic       wb_reg_write,
  output logic       pc_write_en,
  output logic       if_id_write_en,
  output logic       id_ex_write_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_bubble,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b,
  output logic       forward_jr,
  output logic       mul_start,
  output logic       mul_busy
);

  typedef enum logic {RUN, MUL_WAIT} state_t;

  localparam int LOAD = (MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             mul_stall;
  logic             start_c, busy_c;
  logic             load_use, jr_haz;
  logic             mem_alu;

  // $0 is hardwired, so it never aliases a producer
  function automatic logic hit(input logic [4:0] a,
                               input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  assign mem_alu = mem_reg_write & ~mem_mem_read;

  assign load_use = ex_mem_read & ex_reg_write &
    ((id_use_rs & hit(id_rs, ex_wr_addr)) |
     (id_use_rt & hit(id_rt, ex_wr_addr)));

  assign jr_haz = id_is_jr &
    ((ex_reg_write & hit(ex_wr_addr, id_rs)) |
     (mem_mem_read & hit(mem_wr_addr, id_rs)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    mul_stall = 1'b0;
    start_c   = 1'b0;
    busy_c    = 1'b0;
    unique case (state)
      RUN: begin
        if (ex_is_mul) begin
          start_c = 1'b1;
          if (MUL_CYCLES > 1) begin
            mul_stall = 1'b1;
            state_n   = MUL_WAIT;
            cnt_n     = CNT_LOAD;
          end
        end
      end
      MUL_WAIT: begin
        busy_c = 1'b1;
        if (cnt != '0) begin
          mul_stall = 1'b1;
          cnt_n     = cnt - CNT_W'(1);
        end else begin
          state_n = RUN;
        end
      end
    endcase
  end

  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    id_ex_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_bubble  = 1'b0;
    mul_start      = start_c;
    mul_busy       = busy_c;
    forward_a      = 2'b00;
    forward_b      = 2'b00;
    forward_jr     = 1'b0;
    if (!rst_n) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_write_en = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      ex_mem_bubble  = 1'b1;
      mul_start      = 1'b0;
      mul_busy       = 1'b0;
    end else begin
      if (mem_alu && hit(mem_wr_addr, ex_rs))
        forward_a = 2'b10;
      else if (wb_reg_write && hit(wb_wr_addr, ex_rs))
        forward_a = 2'b01;
      if (mem_alu && hit(mem_wr_addr, ex_rt))
        forward_b = 2'b10;
      else if (wb_reg_write && hit(wb_wr_addr, ex_rt))
        forward_b = 2'b01;
      forward_jr = id_is_jr & mem_alu & hit(mem_wr_addr, id_rs);

      if (mul_stall) begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_write_en = 1'b0;
        ex_mem_bubble  = 1'b1;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use || jr_haz) begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_flush    = 1'b1;
      end else if (id_is_jump || id_is_jr) begin
        if_id_flush = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, load-use, JR, branch,
// forwarding and MUL sequencing with MUL_CYCLES=4.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  logic       clk, rst_n;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wr_addr;
  logic [4:0] mem_wr_addr, wb_wr_addr;
  logic       id_use_rs, id_use_rt, id_is_jump, id_is_jr;
  logic       ex_reg_write, ex_mem_read, ex_is_mul;
  logic       ex_branch_taken;
  logic       mem_reg_write, mem_mem_read, wb_reg_write;
  logic       pc_write_en, if_id_write_en, id_ex_write_en;
  logic       if_id_flush, id_ex_flush, ex_mem_bubble;
  logic [1:0] forward_a, forward_b;
  logic       forward_jr, mul_start, mul_busy;

  int n_assert = 0;
  int n_fail   = 0;

  // {pc_we, if_id_we, id_ex_we, if_id_fl, id_ex_fl, bubble, start, busy}
  localparam logic [7:0] C_RST = 8'b000_11_1_00;
  localparam logic [7:0] C_RUN = 8'b111_00_0_00;
  localparam logic [7:0] C_LU  = 8'b001_01_0_00;
  localparam logic [7:0] C_BR  = 8'b111_11_0_00;
  localparam logic [7:0] C_JMP = 8'b111_10_0_00;
  localparam logic [7:0] C_M1  = 8'b000_00_1_10;
  localparam logic [7:0] C_MW  = 8'b000_00_1_01;
  localparam logic [7:0] C_ML  = 8'b111_00_0_01;

  logic [7:0] ctl;
  assign ctl = {pc_write_en, if_id_write_en, id_ex_write_en,
                if_id_flush, id_ex_flush, ex_mem_bubble,
                mul_start, mul_busy};

  hazard_ctrl #(.MUL_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_jump(id_is_jump), .id_is_jr(id_is_jr),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wr_addr(ex_wr_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_is_mul(ex_is_mul), .ex_branch_taken(ex_branch_taken),
    .mem_wr_addr(mem_wr_addr), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read),
    .wb_wr_addr(wb_wr_addr), .wb_reg_write(wb_reg_write),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .id_ex_write_en(id_ex_write_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_bubble(ex_mem_bubble),
    .forward_a(forward_a), .forward_b(forward_b),
    .forward_jr(forward_jr),
    .mul_start(mul_start), .mul_busy(mul_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clr();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_is_jump = 0; id_is_jr = 0;
    ex_rs = 0; ex_rt = 0; ex_wr_addr = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_is_mul = 0;
    ex_branch_taken = 0;
    mem_wr_addr = 0; mem_reg_write = 0; mem_mem_read = 0;
    wb_wr_addr = 0; wb_reg_write = 0;
  endtask

  task automatic rnd();
    id_rs = 5'($urandom); id_rt = 5'($urandom);
    id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
    id_is_jump = 1'($urandom); id_is_jr = 1'($urandom);
    ex_rs = 5'($urandom); ex_rt = 5'($urandom);
    ex_wr_addr = 5'($urandom);
    ex_reg_write = 1'($urandom); ex_mem_read = 1'($urandom);
    ex_is_mul = 1'($urandom); ex_branch_taken = 1'($urandom);
    mem_wr_addr = 5'($urandom); mem_reg_write = 1'($urandom);
    mem_mem_read = 1'($urandom);
    wb_wr_addr = 5'($urandom); wb_reg_write = 1'($urandom);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt(); rnd(); #1;
      chk("rst_ctl", ctl, C_RST);
      chk("rst_fwd", {3'b0, forward_a, forward_b, forward_jr},
          8'h00);
    end

    nxt(); clr(); rst_n = 1'b1; #1;
    chk("rel_run", ctl, C_RUN);

    // lw $8 in EX, add using $8 in ID
    nxt(); ex_mem_read = 1; ex_reg_write = 1; ex_wr_addr = 8;
    id_rs = 8; id_use_rs = 1; #1;
    chk("lu_rs", ctl, C_LU);
    nxt(); clr(); #1;
    chk("lu_one", ctl, C_RUN);
    nxt(); ex_mem_read = 1; ex_reg_write = 1; ex_wr_addr = 0;
    id_rs = 0; id_use_rs = 1; #1;
    chk("lu_r0", ctl, C_RUN);
    nxt(); clr(); ex_mem_read = 1; ex_reg_write = 1;
    ex_wr_addr = 8; id_rt = 8; id_use_rt = 1; #1;
    chk("lu_rt", ctl, C_LU);
    id_use_rt = 0; #1;
    chk("lu_nouse", ctl, C_RUN);
    id_use_rt = 1; id_is_jump = 1; #1;
    chk("lu_jump", ctl, C_LU);
    ex_branch_taken = 1; #1;
    chk("br_lu", ctl, C_BR);

    nxt(); clr(); id_is_jump = 1; #1;
    chk("jump", ctl, C_JMP);

    // forwarding
    nxt(); clr(); mem_reg_write = 1; mem_wr_addr = 5;
    wb_reg_write = 1; wb_wr_addr = 5; ex_rs = 5; #1;
    chk("fwd_a_mem", {6'b0, forward_a}, 8'd2);
    chk("fwd_b_none", {6'b0, forward_b}, 8'd0);
    mem_mem_read = 1; ex_rt = 5; #1;
    chk("fwd_a_wb", {6'b0, forward_a}, 8'd1);
    chk("fwd_b_wb", {6'b0, forward_b}, 8'd1);
    mem_mem_read = 0; mem_wr_addr = 0; wb_wr_addr = 0;
    ex_rs = 0; ex_rt = 0; #1;
    chk("fwd_r0", {4'b0, forward_a, forward_b}, 8'd0);

    // JR target hazards
    nxt(); clr(); id_is_jr = 1; id_rs = 5;
    mem_reg_write = 1; mem_wr_addr = 5; #1;
    chk("jr_fwd", {7'b0, forward_jr}, 8'd1);
    chk("jr_fwd_ctl", ctl, C_JMP);
    mem_mem_read = 1; #1;
    chk("jr_ld_fwd", {7'b0, forward_jr}, 8'd0);
    chk("jr_ld_ctl", ctl, C_LU);
    mem_mem_read = 0; mem_reg_write = 0;
    ex_reg_write = 1; ex_wr_addr = 5; #1;
    chk("jr_ex_ctl", ctl, C_LU);

    // MUL occupying EX for 4 cycles
    nxt(); clr(); ex_is_mul = 1; #1;
    chk("mul_c1", ctl, C_M1);
    nxt(); #1;
    chk("mul_c2", ctl, C_MW);
    ex_branch_taken = 1; #1;
    chk("mul_c2_br", ctl, C_MW);
    ex_branch_taken = 0;
    nxt(); #1;
    chk("mul_c3", ctl, C_MW);
    nxt(); #1;
    chk("mul_c4", ctl, C_ML);
    nxt(); ex_is_mul = 0; #1;
    chk("mul_done", ctl, C_RUN);

    // reset aborting a MUL wait
    nxt(); ex_is_mul = 1; #1;
    chk("rm_c1", ctl, C_M1);
    nxt(); #1;
    chk("rm_c2", ctl, C_MW);
    nxt(); #1;
    chk("rm_c3", ctl, C_MW);
    rst_n = 1'b0; #1;
    chk("rm_rst", ctl, C_RST);
    nxt(); ex_is_mul = 0; rst_n = 1'b1; #1;
    chk("rm_rel", ctl, C_RUN);
    nxt(); #1;
    chk("rm_after", ctl, C_RUN);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
